// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states, lane width.
// Optional build macro used by the responder: DM_ALIGN_CHECK_EN.
package dm_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request/response channel between the core's memory port and the responder.
interface data_mem_responder_if #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9
);

    // Both channels are valid/ready: a beat transfers on a rising edge where valid && ready;
    // the sender holds a response stable while valid is high and ready is low.
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [DM_ADDRESS-1:0] req_addr;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [DATA_W-1:0]     req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dm_lane_unit.sv
// Combinational lane logic: little-endian store byte-merge and load extract/extend.
// Caller passes the effective size; lane bits below the access size are ignored here.
module dm_lane_unit
    import dm_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        size,
    input  logic [1:0]        lane,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] merged,
    output logic [DATA_W-1:0] load_data
);

    logic [4:0]        shamt;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] shifted;

    always_comb begin
        shamt = '0;
        mask  = '1;
        case (size)
            SZ_BYTE: begin
                mask  = DATA_W'({BYTE_W{1'b1}});
                shamt = {lane, 3'b000};
            end
            SZ_HALF: begin
                mask  = DATA_W'({(2*BYTE_W){1'b1}});
                shamt = {lane[1], 4'b0000};
            end
            default: ;
        endcase

        merged    = (old_word & ~(mask << shamt)) | ((wdata & mask) << shamt);
        shifted   = (old_word >> shamt) & mask;
        load_data = shifted;
        if (!is_unsigned) begin
            if (size == SZ_BYTE)
                load_data = {{(DATA_W-BYTE_W){shifted[BYTE_W-1]}}, shifted[BYTE_W-1:0]};
            else if (size == SZ_HALF)
                load_data = {{(DATA_W-2*BYTE_W){shifted[2*BYTE_W-1]}}, shifted[2*BYTE_W-1:0]};
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding load/store, WAIT_CYCLES wait states, held response.
// Define DM_ALIGN_CHECK_EN to fault misaligned and reserved-size accesses instead of force-aligning.
module data_mem_responder
    import dm_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DM_ADDRESS  = 9,
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus,
    output state_t               dbg_state
);

    localparam int IDX_W  = DM_ADDRESS - 2;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  cap_write, cap_unsigned;
    logic [DM_ADDRESS-1:0] cap_addr;
    logic [1:0]            cap_size;
    logic [DATA_W-1:0]     cap_wdata;
    logic [DATA_W-1:0]     rdata_q;
    logic                  err_q;
    logic [DATA_W-1:0]     mem [DEPTH];

    logic                  commit, mem_we;
    logic                  op_write, op_unsigned;
    logic [DM_ADDRESS-1:0] op_addr;
    logic [1:0]            op_size, eff_size;
    logic [DATA_W-1:0]     op_wdata;
    logic [IDX_W-1:0]      op_idx;
    logic [MEM_AW-1:0]     mem_idx;
    logic                  range_err, align_err, op_err;
    logic [DATA_W-1:0]     old_word, merged, load_data;

    // With zero wait states the commit happens on the accept edge, so the live request is used.
    always_comb begin
        if (state_q == ST_IDLE) begin
            op_write    = bus.req_write;
            op_unsigned = bus.req_unsigned;
            op_addr     = bus.req_addr;
            op_size     = bus.req_size;
            op_wdata    = bus.req_wdata;
        end else begin
            op_write    = cap_write;
            op_unsigned = cap_unsigned;
            op_addr     = cap_addr;
            op_size     = cap_size;
            op_wdata    = cap_wdata;
        end
    end

    assign op_idx    = op_addr[DM_ADDRESS-1:2];
    assign mem_idx   = MEM_AW'(op_idx);
    assign range_err = (int'(op_idx) >= DEPTH);
    assign eff_size  = (op_size == 2'b11) ? SZ_WORD : op_size;

`ifdef DM_ALIGN_CHECK_EN
    assign align_err = (op_size == 2'b11)
                     || ((op_size == SZ_HALF) && op_addr[0])
                     || ((op_size == SZ_WORD) && (op_addr[1:0] != 2'b00));
`else
    assign align_err = 1'b0;
`endif

    assign op_err   = range_err || align_err;
    assign old_word = mem[mem_idx];

    dm_lane_unit #(.DATA_W(DATA_W)) u_lane (
        .old_word    (old_word),
        .wdata       (op_wdata),
        .size        (eff_size),
        .lane        (op_addr[1:0]),
        .is_unsigned (op_unsigned),
        .merged      (merged),
        .load_data   (load_data)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        commit        = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                cnt_d         = '0;
                if (bus.req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(WAIT_CYCLES)) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cap_write    <= 1'b0;
            cap_unsigned <= 1'b0;
            cap_addr     <= '0;
            cap_size     <= '0;
            cap_wdata    <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == ST_IDLE && bus.req_valid) begin
                cap_write    <= bus.req_write;
                cap_unsigned <= bus.req_unsigned;
                cap_addr     <= bus.req_addr;
                cap_size     <= bus.req_size;
                cap_wdata    <= bus.req_wdata;
            end
            if (commit) begin
                err_q   <= op_err;
                rdata_q <= (op_err || op_write) ? '0 : load_data;
            end
        end
    end

    // Held reset blocks a zero-wait commit from the idle state while the FSM is frozen.
    assign mem_we = commit && reset && op_write && !op_err;

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= merged;
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-level memory model, per-cycle compare, directed and random traffic.
// Honours DM_ALIGN_CHECK_EN the same way the design does.
module tb_data_mem_responder;
    import dm_pkg::*;

    localparam int DATA_W = 32;
    localparam int AW     = 9;
    localparam int DEPTH  = 64;
    localparam int WAIT   = 2;

    logic   clk   = 1'b0;
    logic   reset = 1'b0;
    state_t dbg_state;

    data_mem_responder_if #(.DATA_W(DATA_W), .DM_ADDRESS(AW)) bus ();

    data_mem_responder #(
        .DATA_W(DATA_W), .DM_ADDRESS(AW), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [31:0]   model_mem [DEPTH];
    logic [32:0]   exp_q[$];           // {err, rdata}
    bit            outstanding = 1'b0;
    bit            rise_seen   = 1'b0;
    bit            in_reset    = 1'b1;
    bit            hold_low    = 1'b0;
    int            accept_edge = 0;
    int            last_latency = 0;
    logic [31:0]   last_rdata = '0;
    logic          last_err   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout required handshake", name);
    endtask

    // Byte-granular reference: picks the covered byte addresses, then assembles/extends.
    function automatic void model_access(input logic wr, input logic [8:0] addr, input logic [1:0] size,
                                         input logic uns, input logic [31:0] wdata, input bit apply,
                                         output logic [31:0] rdata, output logic err);
        int a, idx, nbytes, base;
        logic [31:0] v;
        a      = int'(addr);
        idx    = a / 4;
        rdata  = '0;
        err    = 1'b0;
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
`ifdef DM_ALIGN_CHECK_EN
        if (size == 2'd3) err = 1'b1;
        if ((a % nbytes) != 0) err = 1'b1;
        base = a % 4;
`else
        base = ((a % 4) / nbytes) * nbytes;
`endif
        if (idx >= DEPTH) err = 1'b1;
        if (err) return;
        if (wr) begin
            if (apply)
                for (int i = 0; i < nbytes; i++)
                    model_mem[idx][8*(base+i) +: 8] = wdata[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < nbytes; i++)
                v[8*i +: 8] = model_mem[idx][8*(base+i) +: 8];
            if (!uns && nbytes < 4 && v[8*nbytes-1])
                v = v | (32'hFFFF_FFFF << (8*nbytes));
            rdata = v;
        end
    endfunction

    // ---------------- compare process + response consumer ----------------
    initial begin
        bit ev;
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!in_reset) begin
                ev = outstanding && ((edge_cnt - accept_edge) >= WAIT + 1);
                check("req_ready", 32'(bus.req_ready), 32'(!outstanding));
                check("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
                if (outstanding && bus.rsp_valid && !rise_seen) begin
                    rise_seen    = 1'b1;
                    last_latency = edge_cnt - accept_edge;
                end
                if (ev && exp_q.size() > 0) begin
                    check("rsp_rdata", bus.rsp_rdata, exp_q[0][31:0]);
                    check("rsp_err", 32'(bus.rsp_err), 32'(exp_q[0][32]));
                end
                bus.rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
                if (ev && bus.rsp_ready) begin
                    last_rdata = bus.rsp_rdata;
                    last_err   = bus.rsp_err;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    outstanding = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done();
        int n;
        n = 0;
        while (outstanding && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (outstanding) begin
            fail_bound("response_timeout");
            outstanding = 1'b0;
            exp_q.delete();
        end
    endtask

    task automatic send(input logic wr, input logic [8:0] addr, input logic [1:0] size, input logic uns,
                        input logic [31:0] wdata, input bit apply,
                        output logic [31:0] mr, output logic me);
        int n;
        wait_done();
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_addr     = addr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_wdata    = wdata;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            fail_bound("accept_timeout");
            bus.req_valid = 1'b0;
            mr = '0;
            me = 1'b0;
            return;
        end
        model_access(wr, addr, size, uns, wdata, apply, mr, me);
        exp_q.push_back({me, mr});
        @(posedge clk);
        #1;
        accept_edge      = edge_cnt;
        rise_seen        = 1'b0;
        outstanding      = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'($urandom);
        bus.req_addr     = 9'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_wdata    = $urandom;
    endtask

    task automatic txn_lit(input string name, input logic wr, input logic [8:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata,
                           input logic [31:0] lit_r, input logic lit_e);
        logic [31:0] mr;
        logic        me;
        send(wr, addr, size, uns, wdata, 1'b1, mr, me);
        check({name, "_model"}, mr, lit_r);
        wait_done();
        check(name, last_rdata, lit_r);
        check({name, "_err"}, 32'(last_err), 32'(lit_e));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] mr;
        logic        me;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_addr     = '0;
        bus.req_size     = '0;
        bus.req_unsigned = 1'b0;
        bus.req_wdata    = '0;

        #1;
        check("reset_req_ready", 32'(bus.req_ready), 32'd1);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        repeat (3) @(negedge clk);
        reset    = 1'b1;
        in_reset = 1'b0;

        // Give every word a known value so random loads have a defined expectation.
        for (int i = 0; i < DEPTH; i++)
            send(1'b1, 9'(i*4), SZ_WORD, 1'b0, (i == 0) ? 32'h0BAD_F00D : $urandom, 1'b1, mr, me);

        txn_lit("st_word", 1'b1, 9'h010, SZ_WORD, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0);
        txn_lit("ld_word", 1'b0, 9'h010, SZ_WORD, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        check("latency", 32'(last_latency), 32'd3);
        txn_lit("st_byte", 1'b1, 9'h011, SZ_BYTE, 1'b0, 32'h1234_565A, 32'h0, 1'b0);
        txn_lit("ld_merged", 1'b0, 9'h010, SZ_WORD, 1'b0, 32'h0, 32'hDEAD_5AEF, 1'b0);
        txn_lit("ld_byte_s", 1'b0, 9'h013, SZ_BYTE, 1'b0, 32'h0, 32'hFFFF_FFDE, 1'b0);
        txn_lit("ld_byte_u", 1'b0, 9'h013, SZ_BYTE, 1'b1, 32'h0, 32'h0000_00DE, 1'b0);
`ifdef DM_ALIGN_CHECK_EN
        txn_lit("ld_half_mis", 1'b0, 9'h013, SZ_HALF, 1'b0, 32'h0, 32'h0, 1'b1);
`else
        txn_lit("ld_half_mis", 1'b0, 9'h013, SZ_HALF, 1'b0, 32'h0, 32'hFFFF_DEAD, 1'b0);
`endif

        // Response held back while a competing store to the same word is presented.
        hold_low = 1'b1;
        send(1'b0, 9'h010, SZ_WORD, 1'b0, 32'h0, 1'b1, mr, me);
        repeat (4) @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 9'h010;
        bus.req_size  = SZ_WORD;
        bus.req_wdata = 32'hFFFF_FFFF;
        repeat (5) @(negedge clk);
        bus.req_valid = 1'b0;
        hold_low      = 1'b0;
        wait_done();
        check("held_rdata", last_rdata, 32'hDEAD_5AEF);
        txn_lit("after_hold", 1'b0, 9'h010, SZ_WORD, 1'b0, 32'h0, 32'hDEAD_5AEF, 1'b0);

        txn_lit("st_oor", 1'b1, 9'h100, SZ_WORD, 1'b0, 32'h1111_1111, 32'h0, 1'b1);
        txn_lit("ld_word0", 1'b0, 9'h000, SZ_WORD, 1'b0, 32'h0, 32'h0BAD_F00D, 1'b0);

        // Abandon a store mid-wait; the array must keep its earlier contents.
        txn_lit("st_pre", 1'b1, 9'h020, SZ_WORD, 1'b0, 32'hCAFE_BABE, 32'h0, 1'b0);
        txn_lit("ld_pre", 1'b0, 9'h020, SZ_WORD, 1'b0, 32'h0, 32'hCAFE_BABE, 1'b0);
        send(1'b1, 9'h020, SZ_WORD, 1'b0, 32'h1234_5678, 1'b0, mr, me);
        @(posedge clk);
        #2;
        in_reset = 1'b1;
        reset    = 1'b0;
        #1;
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("abort_rsp_err", 32'(bus.rsp_err), 32'd0);
        outstanding = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset    = 1'b1;
        in_reset = 1'b0;
        txn_lit("ld_post", 1'b0, 9'h020, SZ_WORD, 1'b0, 32'h0, 32'hCAFE_BABE, 1'b0);

        for (int i = 0; i < 250; i++)
            send(1'($urandom_range(0, 1)), 9'($urandom_range(0, DEPTH*4 + 31)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom, 1'b1, mr, me);
        wait_done();
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
